// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding, grant identity, default bus widths.
package sdram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_ACK   = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/sdram_port_arbiter_timeout_counter.sv
// Read-wait cycle counter; tc is high during the TIMEOUT-th counted cycle.
// Zero latency from count to tc; count holds when neither clear nor count_en is asserted.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic count_en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tc = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM port between a read and a write requester.
// Registered outputs; strobes one cycle after grant; requesters are held off while busy.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] data_sdram,
  input  logic              sdram_datareadvalid,
  output logic              sdram_read_en,
  output logic              sdram_write_en,
  output logic [ADDR_W-1:0] address_sdram,
  output logic [DATA_W-1:0] writeData_sdram,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_timeout,
  output logic              wr_ack,
  output logic              busy
);

  arb_state_t        r_state;
  grant_t            r_last_grant;
  logic              r_read_en;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_timeout;
  logic              r_wr_ack;
  logic              r_busy;

  logic w_grant_rd;
  logic w_grant_wr;
  logic w_wait;
  logic w_tc;

  // On a tie the requester that did not win last time gets the port.
  assign w_grant_rd = rd_req && (!wr_req || (r_last_grant == GRANT_WR));
  assign w_grant_wr = wr_req && !w_grant_rd;
  assign w_wait     = (r_state == RD_WAIT);

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (!w_wait),
    .count_en (w_wait),
    .tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_WR;
      r_read_en    <= 1'b0;
      r_write_en   <= 1'b0;
      r_address    <= '0;
      r_wdata      <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_timeout <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_read_en    <= 1'b0;
      r_write_en   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_timeout <= 1'b0;
      r_wr_ack     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_rd) begin
            r_state      <= RD_ISSUE;
            r_last_grant <= GRANT_RD;
            r_address    <= rd_addr;
            r_read_en    <= 1'b1;
            r_busy       <= 1'b1;
          end else if (w_grant_wr) begin
            r_state      <= WR_ISSUE;
            r_last_grant <= GRANT_WR;
            r_address    <= wr_addr;
            r_wdata      <= wr_data;
            r_write_en   <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        RD_ISSUE: begin
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Data arriving on the terminal cycle still counts as a successful read.
          if (sdram_datareadvalid) begin
            r_rd_data  <= data_sdram;
            r_rd_valid <= 1'b1;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else if (w_tc) begin
            r_rd_timeout <= 1'b1;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end
        end
        WR_ISSUE: begin
          r_wr_ack <= 1'b1;
          r_state  <= WR_ACK;
        end
        WR_ACK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sdram_read_en   = r_read_en;
  assign sdram_write_en  = r_write_en;
  assign address_sdram   = r_address;
  assign writeData_sdram = r_wdata;
  assign rd_valid        = r_rd_valid;
  assign rd_data         = r_rd_data;
  assign rd_timeout      = r_rd_timeout;
  assign wr_ack          = r_wr_ack;
  assign busy            = r_busy;

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 26, SDRAM word address width; DATA_W, default 32, SDRAM data width; TIMEOUT, default 16, maximum cycles spent waiting for read data.
REQ-002 Ports (clock and reset first), in order:
- clk, in, 1: single clock; all logic is rising-edge.
- n_rst, in, 1: synchronous active-low reset.
- rd_req, in, 1: read requester asks for a word; held until rd_valid or rd_timeout.
- rd_addr, in, ADDR_W: read word address.
- wr_req, in, 1: write requester asks to store a word; held until wr_ack.
- wr_addr, in, ADDR_W: write word address.
- wr_data, in, DATA_W: write word.
- data_sdram, in, DATA_W: SDRAM read data.
- sdram_datareadvalid, in, 1: data_sdram is valid this cycle.
- sdram_read_en, out, 1: one-cycle SDRAM read strobe.
- sdram_write_en, out, 1: one-cycle SDRAM write strobe.
- address_sdram, out, ADDR_W: SDRAM address.
- writeData_sdram, out, DATA_W: SDRAM write data.
- rd_valid, out, 1: one-cycle pulse; rd_data is valid.
- rd_data, out, DATA_W: captured read word.
- rd_timeout, out, 1: one-cycle pulse; the read was abandoned.
- wr_ack, out, 1: one-cycle pulse; the write was issued.
- busy, out, 1: FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have five states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_ACK.
REQ-004 All outputs SHALL be registered.
REQ-005 In IDLE with only rd_req high, the FSM SHALL go to RD_ISSUE and latch rd_addr.
REQ-006 In IDLE with only wr_req high, the FSM SHALL go to WR_ISSUE and latch wr_addr and wr_data.
REQ-007 With rd_req and wr_req both high in IDLE, the FSM SHALL grant the requester not granted last (round-robin); the last_grant bit updates on each grant.
REQ-008 RD_ISSUE SHALL last exactly one cycle: sdram_read_en=1, address_sdram=latched address; next state RD_WAIT.
REQ-009 In RD_WAIT, sdram_read_en SHALL be 0 and address_sdram SHALL hold the latched address.
REQ-010 In RD_WAIT, a sampled sdram_datareadvalid=1 SHALL capture data_sdram into rd_data, pulse rd_valid for one cycle on the next cycle, and return the FSM to IDLE.
REQ-011 RD_WAIT SHALL count cycles from 0; if TIMEOUT cycles elapse without sdram_datareadvalid, rd_timeout SHALL pulse once, rd_valid SHALL stay 0, rd_data SHALL be unchanged, and the FSM SHALL return to IDLE.
REQ-012 sdram_datareadvalid SHALL be ignored in every state except RD_WAIT.
REQ-013 If sdram_datareadvalid arrives on the same cycle the timeout expires, the data SHALL win: rd_valid pulses, rd_timeout does not.
REQ-014 WR_ISSUE SHALL last exactly one cycle: sdram_write_en=1, address_sdram and writeData_sdram = latched values; next state WR_ACK.
REQ-015 WR_ACK SHALL pulse wr_ack for one cycle and return to IDLE.
REQ-016 sdram_read_en and sdram_write_en SHALL never be high in the same cycle.
REQ-017 Any request seen at IDLE SHALL be granted, giving a minimum 1-cycle idle gap between transactions.
REQ-018 Request-input changes outside IDLE SHALL not affect the latched address or data.
REQ-019 busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 n_rst=0 sampled at a rising edge SHALL force: state IDLE; all strobes and pulses 0; address_sdram, writeData_sdram and rd_data all 0; timeout counter 0; last_grant = write, so a read wins the first tie.
REQ-021 Reset asserted mid-transaction SHALL abort it with no rd_valid, rd_timeout or wr_ack pulse.

Structure
REQ-022 A shared package SHALL hold the state enum and the default ADDR_W and DATA_W constants.
REQ-023 The RD_WAIT counter SHALL be the sub-module arb_timeout_counter, with ports clk, n_rst, clear, count_en, and a terminal-count output.

Verification
REQ-024 Read with data after 2 cycles: rd_req=1, rd_addr=0x000010, data_sdram=0xFF102030 with sdram_datareadvalid on the 2nd RD_WAIT cycle -> sdram_read_en high exactly 1 cycle, address_sdram=0x000010 through RD_WAIT, rd_valid=1 with rd_data=0xFF102030.
REQ-025 Write: wr_req=1, wr_addr=0x000005, wr_data=0x00ABCDEF -> sdram_write_en for 1 cycle with address_sdram=0x000005 and writeData_sdram=0x00ABCDEF, then wr_ack for 1 cycle.
REQ-026 Both requesters held high for 4 transactions after reset -> grant order read, write, read, write.
REQ-027 Read with no sdram_datareadvalid, TIMEOUT=16 -> rd_timeout pulses once after 16 RD_WAIT cycles, rd_valid stays 0, busy falls.
REQ-028 n_rst=0 during RD_WAIT -> next cycle all outputs are 0, no rd_valid follows, and a new rd_req is then serviced normally.
REQ-029 sdram_datareadvalid=1 while IDLE with data_sdram=0x12345678 -> rd_valid stays 0 and rd_data is unchanged.
